// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } hilo_state_t;

  localparam int DIV_ITERS = 32;

  // Divide-by-zero yields an all-ones quotient; HI returns the raw dividend.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic is_md(input md_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_ctrl_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step
  import hilo_pkg::*;
(
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dsr,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // Bit 32 of diff acts as the borrow: set when the shifted remainder is below the divisor.
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dsr};
    if (diff[32]) begin
      rem_next = shifted[31:0];
      quo_next = {quo[30:0], 1'b0};
    end else begin
      rem_next = diff[31:0];
      quo_next = {quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// Multiply/divide sequencer owning HI/LO: pipelined multiplier, iterative divider,
// pipeline stall generation and flush handling.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  md_op_t      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  hilo_state_t state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  md_op_t      op_reg;
  logic [31:0] a_reg;
  logic [63:0] prod_reg;
  logic [31:0] rem_reg, quo_reg, dsr_reg;
  logic        neg_q_reg, neg_r_reg, div0_reg;
  logic [31:0] hi_reg, lo_reg;

  logic        signed_op, accept, mt_write, is_mul_in;
  logic [32:0] ext_a, ext_b;
  logic signed [65:0] prod_full;
  logic [31:0] mag_a, mag_b;
  logic [31:0] step_rem, step_quo, step_dsr, step_rem_next, step_quo_next;
  logic [31:0] res_hi, res_lo;

  assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign is_mul_in = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign accept    = !flush_i && (state_reg == ST_IDLE) && req_i && is_md(op_i);
  assign mt_write  = !flush_i && (state_reg == ST_IDLE) && req_i &&
                     ((op_i == OP_MTHI) || (op_i == OP_MTLO));

  // The single pipeline stage of the multiplier is captured on the accept edge.
  assign ext_a     = {signed_op & a_i[31], a_i};
  assign ext_b     = {signed_op & b_i[31], b_i};
  assign prod_full = $signed(ext_a) * $signed(ext_b);

  assign mag_a = mag(a_i, signed_op);
  assign mag_b = mag(b_i, signed_op);

  // The first divide iteration runs on the accept edge straight from the operands,
  // which is what lets 32 iterations fit in 32 stall cycles.
  assign step_rem = (state_reg == ST_DIV) ? rem_reg : 32'd0;
  assign step_quo = (state_reg == ST_DIV) ? quo_reg : mag_a;
  assign step_dsr = (state_reg == ST_DIV) ? dsr_reg : mag_b;

  div_step u_div_step (
    .rem      (step_rem),
    .quo      (step_quo),
    .dsr      (step_dsr),
    .rem_next (step_rem_next),
    .quo_next (step_quo_next)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul_in) begin
            state_next = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
            cnt_next   = 6'(MUL_LAT - 1);
          end else begin
            state_next = ST_DIV;
            cnt_next   = 6'(DIV_ITERS - 1);
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush_i) begin
          state_next = ST_IDLE;
          cnt_next   = 6'd0;
        end else begin
          cnt_next = cnt_reg - 6'd1;
          if (cnt_reg == 6'd1) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = 6'd0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 6'd0;
      end
    endcase
  end

  always_comb begin
    stall_o = !reset && !flush_i &&
              (((state_reg == ST_IDLE) && req_i && is_md(op_i)) ||
               (state_reg == ST_MUL) || (state_reg == ST_DIV));
    done_o  = !reset && !flush_i && (state_reg == ST_DONE);
  end

  always_comb begin
    res_hi = prod_reg[63:32];
    res_lo = prod_reg[31:0];
    if ((op_reg == OP_DIV) || (op_reg == OP_DIVU)) begin
      if (div0_reg) begin
        res_hi = a_reg;
        res_lo = DIV0_LO;
      end else begin
        res_hi = neg_r_reg ? (32'd0 - rem_reg) : rem_reg;
        res_lo = neg_q_reg ? (32'd0 - quo_reg) : quo_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 6'd0;
      op_reg    <= OP_NONE;
      a_reg     <= 32'd0;
      prod_reg  <= 64'd0;
      rem_reg   <= 32'd0;
      quo_reg   <= 32'd0;
      dsr_reg   <= 32'd0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      div0_reg  <= 1'b0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        op_reg    <= op_i;
        a_reg     <= a_i;
        prod_reg  <= prod_full[63:0];
        rem_reg   <= step_rem_next;
        quo_reg   <= step_quo_next;
        dsr_reg   <= mag_b;
        neg_q_reg <= signed_op && (a_i[31] ^ b_i[31]);
        neg_r_reg <= signed_op && a_i[31];
        div0_reg  <= (b_i == 32'd0);
      end
      if (state_reg == ST_DIV) begin
        rem_reg <= step_rem_next;
        quo_reg <= step_quo_next;
      end
      if (mt_write) begin
        if (op_i == OP_MTHI) hi_reg <= a_i;
        else                 lo_reg <= a_i;
      end
      if (done_o) begin
        hi_reg <= res_hi;
        lo_reg <= res_lo;
      end
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed self-checking bench for hilo_ctrl: MTHI/MTLO, multiply, divide, flush and reset.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i;
  md_op_t      op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  task automatic drive_now(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    req_i = 1'b1;
    op_i  = op;
    a_i   = a;
    b_i   = b;
  endtask

  task automatic drive(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    drive_now(op, a, b);
  endtask

  // Holds the request until the done cycle has passed; returns stall count and whether done_o fired.
  task automatic wait_done(output int stalls, output bit got);
    stalls = 0;
    got    = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (done_o)  got = 1'b1;
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    op_i  = OP_NONE;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || stall_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got hi=%h lo=%h stall=%b done=%b exp 0/0/0/0", hi_o, lo_o, stall_o, done_o);
    end
    $display("txn reset hi=%h lo=%h", hi_o, lo_o);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_mt;
    drive(OP_MTHI, 32'h1234_5678, 32'd0);
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL mthi_flags got stall=%b done=%b exp 0/0", stall_o, done_o);
    end
    @(posedge clk); #1;
    drive_now(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    total++;
    if (hi_o !== 32'h1234_5678) begin
      bad++;
      $display("FAIL mthi_value got=%h exp=12345678", hi_o);
    end
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL mtlo_flags got stall=%b done=%b exp 0/0", stall_o, done_o);
    end
    @(posedge clk); #1;
    req_i = 1'b0;
    op_i  = OP_NONE;
    total++;
    if (lo_o !== 32'h9ABC_DEF0 || hi_o !== 32'h1234_5678) begin
      bad++;
      $display("FAIL mtlo_value got hi=%h lo=%h exp 12345678/9abcdef0", hi_o, lo_o);
    end
    $display("txn mthi/mtlo hi=%h lo=%h", hi_o, lo_o);
  endtask

  task automatic test_mul;
    int s;
    bit g;
    drive(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done(s, g);
    total++;
    if (s !== MUL_LAT || !g || hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFA) begin
      bad++;
      $display("FAIL mult_neg got stalls=%0d done=%b hi=%h lo=%h exp %0d/1/ffffffff/fffffffa",
               s, g, hi_o, lo_o, MUL_LAT);
    end
    $display("txn mult a=fffffffe b=3 stalls=%0d hi=%h lo=%h", s, hi_o, lo_o);
    @(negedge clk);
    total++;
    if (done_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got done=%b stall=%b exp 0/0", done_o, stall_o);
    end
  endtask

  // Each op is presented in the cycle immediately after the previous DONE.
  task automatic test_back_to_back;
    md_op_t      ops   [5] = '{OP_MULTU, OP_DIV, OP_DIVU, OP_DIVU, OP_DIV};
    logic [31:0] as    [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000};
    logic [31:0] bs    [5] = '{32'd3, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] exp_hi[5] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd0};
    logic [31:0] exp_lo[5] = '{32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
    int          exp_st[5] = '{MUL_LAT, 32, 32, 32, 32};
    int s;
    bit g;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive_now(ops[i], as[i], bs[i]);
      wait_done(s, g);
      total++;
      if (s !== exp_st[i] || !g || hi_o !== exp_hi[i] || lo_o !== exp_lo[i]) begin
        bad++;
        $display("FAIL b2b_%0d got stalls=%0d done=%b hi=%h lo=%h exp %0d/1/%h/%h",
                 i, s, g, hi_o, lo_o, exp_st[i], exp_hi[i], exp_lo[i]);
      end
      $display("txn op=%0d a=%h b=%h stalls=%0d hi=%h lo=%h", ops[i], as[i], bs[i], s, hi_o, lo_o);
    end
  endtask

  task automatic test_flush_idle;
    logic [31:0] hi_before;
    hi_before = hi_o;
    flush_i   = 1'b1;
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle_stall got=%b exp=0", stall_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    req_i   = 1'b0;
    op_i    = OP_NONE;
    total++;
    if (hi_o !== hi_before) begin
      bad++;
      $display("FAIL flush_idle_mthi got=%h exp=%h", hi_o, hi_before);
    end
    $display("txn mthi under flush hi=%h", hi_o);
  endtask

  task automatic test_flush_div;
    int s;
    bit g;
    int extra_stall;
    int extra_done;
    drive(OP_MTHI, 32'h1111_1111, 32'd0);
    drive(OP_MTLO, 32'h1111_1111, 32'd0);
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_cycle got stall=%b done=%b exp 0/0", stall_o, done_o);
    end
    @(posedge clk); #1;
    flush_i     = 1'b0;
    req_i       = 1'b0;
    op_i        = OP_NONE;
    extra_stall = 0;
    extra_done  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall_o) extra_stall++;
      if (done_o)  extra_done++;
    end
    total++;
    if (extra_stall != 0 || extra_done != 0 || hi_o !== 32'h1111_1111 || lo_o !== 32'h1111_1111) begin
      bad++;
      $display("FAIL flush_div got stalls=%0d dones=%0d hi=%h lo=%h exp 0/0/11111111/11111111",
               extra_stall, extra_done, hi_o, lo_o);
    end
    $display("txn div flushed hi=%h lo=%h", hi_o, lo_o);
    drive(OP_MULT, 32'd6, 32'd7);
    wait_done(s, g);
    total++;
    if (s !== MUL_LAT || !g || hi_o !== 32'd0 || lo_o !== 32'd42) begin
      bad++;
      $display("FAIL mult_after_flush got stalls=%0d done=%b hi=%h lo=%h exp %0d/1/0/2a",
               s, g, hi_o, lo_o, MUL_LAT);
    end
    $display("txn mult a=6 b=7 stalls=%0d hi=%h lo=%h", s, hi_o, lo_o);
  endtask

  task automatic test_reset_mid_div;
    int s;
    bit g;
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_flags got stall=%b done=%b exp 0/0", stall_o, done_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_regs got hi=%h lo=%h stall=%b exp 0/0/0", hi_o, lo_o, stall_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    wait_done(s, g);
    total++;
    if (s !== 32 || !g || hi_o !== 32'd2 || lo_o !== 32'd14) begin
      bad++;
      $display("FAIL div_after_reset got stalls=%0d done=%b hi=%h lo=%h exp 32/1/2/e", s, g, hi_o, lo_o);
    end
    $display("txn div after reset stalls=%0d hi=%h lo=%h", s, hi_o, lo_o);
  endtask

  initial begin
    reset   = 1'b1;
    req_i   = 1'b0;
    op_i    = OP_NONE;
    a_i     = 32'd0;
    b_i     = 32'd0;
    flush_i = 1'b0;
    test_reset();
    test_mt();
    test_mul();
    test_back_to_back();
    test_flush_idle();
    test_flush_div();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Sequences multiply/divide instructions for the execute stage and owns the architectural HI/LO registers.
- Runs a pipelined multiplier and an iterative restoring divider.
- Stalls the pipeline until a result is ready, then commits it to HI/LO.
- Handles MTHI/MTLO writes and aborts in-flight work on pipeline flush (exception).

Parameters:
- MUL_LAT, 2, cycles of stall_o for MULT/MULTU (range 1..8).
- DIV_ITERS, 32, radix-2 iterations per divide; fixed to the 32-bit operand width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_i  in  1  execute stage presents an op this cycle; held stable while stall_o=1.
- op_i  in  3  md_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- a_i  in  32  rs value (dividend / multiplicand / MTHI-MTLO data).
- b_i  in  32  rt value (divisor / multiplier).
- flush_i  in  1  kill in-flight op; no HI/LO write.
- stall_o  out  1  freeze the pipeline (combinational).
- done_o  out  1  one-cycle pulse in the cycle HI/LO is written.
- hi_o  out  32  registered HI.
- lo_o  out  32  registered LO.

Behaviour:
- Reset: state=IDLE, hi_o=lo_o=0, stall_o=0, done_o=0, counter=0. Reset overrides flush_i and req_i.
- States:
  - IDLE: accept when req_i=1, flush_i=0 and op_i is MULT/MULTU/DIV/DIVU. Latch operands and op, load counter, go to MUL or DIV.
  - MUL: count down MUL_LAT-1; product is pipelined internally; then go to DONE.
  - DIV: one restoring step per cycle on magnitudes; after DIV_ITERS steps go to DONE.
  - DONE: apply sign fix, write HI/LO on this cycle's edge, done_o=1, return to IDLE.
- stall_o = !flush_i && ((IDLE && req_i && op is mul/div) || state==MUL || state==DIV). It is 0 in DONE so the instruction advances in the same cycle its result commits.
- Latency, accept at cycle T:
  - MULT: stall_o high T..T+MUL_LAT-1, DONE at T+MUL_LAT, new HI/LO visible from T+MUL_LAT+1.
  - DIV: stall_o high T..T+31, DONE at T+32, new HI/LO visible from T+33.
- MTHI/MTLO: accepted only in IDLE, no stall. hi_o or lo_o takes a_i on that edge (visible next cycle); done_o stays 0.
- Requests while not IDLE, and op NONE, are ignored. The pipeline is stalled, so no legal new op can arrive.
- MULT is signed 32x32->64 and MULTU unsigned. HI = product[63:32], LO = product[31:0].
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed: operate on magnitudes. Quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - b=0 (either form): LO=0xFFFFFFFF, HI=a_i. No trap.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- flush_i:
  - In MUL/DIV/DONE: go to IDLE next cycle, no HI/LO write, done_o=0 in that cycle.
  - In IDLE: blocks acceptance, including MTHI/MTLO.
- A new req on the cycle after DONE is accepted normally; back-to-back ops are allowed.

Decomposition:
- Shared package hilo_pkg:
  - md_op_t enum (3-bit).
  - hilo_state_t enum {IDLE, MUL, DIV, DONE}.
  - DIV_ITERS constant.
  - Divide-by-zero result constants.
- One sub-module, div_step: combinational single restoring iteration. Takes partial remainder, quotient shift register and divisor magnitude; returns the next remainder and quotient. It is instantiated once and registered by hilo_ctrl.

Test Plan:
- Reset, then MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> stall_o=0 throughout; hi_o=0x12345678 and lo_o=0x9ABCDEF0 one cycle after each request.
- MULT a=0xFFFFFFFE (-2), b=3 -> stall_o high for exactly MUL_LAT cycles, done_o pulse, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> stall_o high for exactly 32 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=LO=0x11111111, start DIV, assert flush_i at cycle T+10 -> stall_o=0 in that cycle, IDLE next cycle, no done_o, HI/LO still 0x11111111. Then MULT 6x7 -> LO=42, HI=0.
- Assert reset mid-DIV -> next cycle hi_o=lo_o=0, stall_o=0, IDLE. A req held high during reset is not accepted until reset deasserts.
